calc_seq_alu: RTL and testbench

- Multi-cycle arithmetic stage for the switch calculator.
- Sits between the button/function-select logic and the result memory. It takes one start pulse plus an op code and two 8-bit operands, and computes a 16-bit result.
- Multiply uses shift-add and divide uses restoring division, each iterated over WIDTH cycles. This replaces single-cycle wide combinational multiply/divide.
- Presents result, memory write address and a one-cycle write strobe to the downstream memory.

---
 rtl/calc_pkg.sv | 49 ++++
 rtl/calc_muldiv_iter.sv | 62 ++++++
 rtl/calc_seq_alu.sv | 165 ++++++++++++++++
 tb/tb_calc_seq_alu.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared constants for the calculator arithmetic stage.
// Holds op codes, memory slot addresses, FSM encoding and op decode helpers.
package calc_pkg;

    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_DIV = 3'b100;

    localparam logic [1:0] ADDR_ADD = 2'b00;
    localparam logic [1:0] ADDR_MUL = 2'b01;
    localparam logic [1:0] ADDR_SUB = 2'b10;
    localparam logic [1:0] ADDR_DIV = 2'b11;

    localparam logic MODE_MUL = 1'b0;
    localparam logic MODE_DIV = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    function automatic logic op_valid(input logic [2:0] op);
        logic v;
        v = 1'b0;
        unique case (1'b1)
            (op == OP_ADD): v = 1'b1;
            (op == OP_MUL): v = 1'b1;
            (op == OP_SUB): v = 1'b1;
            (op == OP_DIV): v = 1'b1;
            default:        v = 1'b0;
        endcase
        return v;
    endfunction

    function automatic logic [1:0] op_addr(input logic [2:0] op);
        logic [1:0] ad;
        ad = ADDR_ADD;
        unique case (1'b1)
            (op == OP_MUL): ad = ADDR_MUL;
            (op == OP_SUB): ad = ADDR_SUB;
            (op == OP_DIV): ad = ADDR_DIV;
            default:        ad = ADDR_ADD;
        endcase
        return ad;
    endfunction

endpackage

// File: rtl/calc_muldiv_iter.sv
// Shared iterative datapath: shift-add multiply and restoring divide.
// Ports: load/a/b seed the accumulator, step advances one iteration,
// mode selects mul/div, acc_hi/acc_lo show the post-step accumulator.
module calc_muldiv_iter
    import calc_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] acc_hi,
    output logic [WIDTH-1:0] acc_lo
);

    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_b;

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_trial;
    logic [WIDTH-1:0] w_diff;
    logic             w_ge;

    // acc_* are combinational post-step values so the caller can
    // capture the final answer on the same edge as the last step.
    always_comb begin
        w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
        w_trial = {r_hi, r_lo[WIDTH-1]};
        w_ge    = (w_trial >= {1'b0, r_b});
        // Partial remainder stays below the divisor, so the
        // low WIDTH bits of the difference are exact.
        w_diff  = w_trial[WIDTH-1:0] - r_b;
        if (mode == MODE_DIV) begin
            acc_hi = w_ge ? w_diff : w_trial[WIDTH-1:0];
            acc_lo = {r_lo[WIDTH-2:0], w_ge};
        end else begin
            acc_hi = w_sum[WIDTH:1];
            acc_lo = {w_sum[0], r_lo[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hi <= '0;
            r_lo <= '0;
            r_b  <= '0;
        end else if (load) begin
            r_hi <= '0;
            r_lo <= a;
            r_b  <= b;
        end else if (step) begin
            r_hi <= acc_hi;
            r_lo <= acc_lo;
        end
    end

endmodule

// File: rtl/calc_seq_alu.sv
// Multi-cycle calculator ALU: add/sub in one step, mul/div iterated.
// Ports: start/op/a/b request; busy, done strobe, result, rem,
// wr_addr and err toward the result memory.
module calc_seq_alu
    import calc_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [2:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] result,
    output logic [WIDTH-1:0]   rem,
    output logic [1:0]         wr_addr,
    output logic               err
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t r_state;
    state_t w_nxt;

    logic [2:0]         r_op;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [1:0]         r_lat_addr;
    logic [CNT_W-1:0]   r_cnt;
    logic [2*WIDTH-1:0] r_result;
    logic [WIDTH-1:0]   r_rem;
    logic [1:0]         r_wr_addr;
    logic               r_err;

    logic               w_accept;
    logic               w_step;
    logic               w_cap;
    logic [2*WIDTH-1:0] w_res;
    logic [WIDTH-1:0]   w_rem;
    logic               w_err;
    logic               w_mode;
    logic [WIDTH-1:0]   w_hi;
    logic [WIDTH-1:0]   w_lo;

    assign w_mode = (r_op == OP_DIV) ? MODE_DIV : MODE_MUL;

    calc_muldiv_iter #(
        .WIDTH (WIDTH)
    ) u_iter (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (w_accept),
        .step   (w_step),
        .mode   (w_mode),
        .a      (a),
        .b      (b),
        .acc_hi (w_hi),
        .acc_lo (w_lo)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_nxt;
    end

    always_comb begin
        w_nxt    = r_state;
        w_accept = 1'b0;
        w_step   = 1'b0;
        w_cap    = 1'b0;
        w_res    = '0;
        w_rem    = '0;
        w_err    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start && op_valid(op)) begin
                    w_accept = 1'b1;
                    w_nxt    = ST_CALC;
                end
            end
            ST_CALC: begin
                case (r_op)
                    OP_ADD: begin
                        w_cap = 1'b1;
                        w_res = {{WIDTH{1'b0}}, r_a}
                              + {{WIDTH{1'b0}}, r_b};
                    end
                    OP_SUB: begin
                        w_cap = 1'b1;
                        w_res = {{WIDTH{1'b0}}, r_a}
                              - {{WIDTH{1'b0}}, r_b};
                    end
                    OP_MUL: begin
                        w_step = 1'b1;
                        w_cap  = (r_cnt == LAST);
                        w_res  = {w_hi, w_lo};
                    end
                    OP_DIV: begin
                        if (r_b == '0) begin
                            w_cap = 1'b1;
                            w_res = '1;
                            w_rem = '1;
                            w_err = 1'b1;
                        end else begin
                            w_step = 1'b1;
                            w_cap  = (r_cnt == LAST);
                            w_res  = {{WIDTH{1'b0}}, w_lo};
                            w_rem  = w_hi;
                        end
                    end
                    default: w_cap = 1'b1;
                endcase
                if (w_cap) w_nxt = ST_DONE;
            end
            ST_DONE: w_nxt = ST_IDLE;
            default: w_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op       <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_lat_addr <= ADDR_ADD;
            r_cnt      <= '0;
        end else if (w_accept) begin
            r_op       <= op;
            r_a        <= a;
            r_b        <= b;
            r_lat_addr <= op_addr(op);
            r_cnt      <= '0;
        end else if (w_step && !w_cap) begin
            r_cnt      <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result  <= '0;
            r_rem     <= '0;
            r_wr_addr <= ADDR_ADD;
            r_err     <= 1'b0;
        end else if (w_accept) begin
            r_err     <= 1'b0;
        end else if (w_cap) begin
            r_result  <= w_res;
            r_rem     <= w_rem;
            r_wr_addr <= r_lat_addr;
            r_err     <= w_err;
        end
    end

    assign busy    = (r_state != ST_IDLE);
    assign done    = (r_state == ST_DONE);
    assign result  = r_result;
    assign rem     = r_rem;
    assign wr_addr = r_wr_addr;
    assign err     = r_err;

endmodule

// File: tb/tb_calc_seq_alu.sv
// Self-checking bench for calc_seq_alu.
// Directed cases plus randomized ops against a behavioural model.
module tb_calc_seq_alu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [7:0]  a = 8'd0;
    logic [7:0]  b = 8'd0;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic [7:0]  rem;
    logic [1:0]  wr_addr;
    logic        err;

    int n_chk = 0;
    int n_pass = 0;

    logic [15:0] e_res = 16'd0;
    logic [7:0]  e_rem = 8'd0;
    logic [1:0]  e_addr = 2'd0;
    logic        e_err = 1'b0;

    calc_seq_alu #(.WIDTH(8), .CNT_W(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .rem     (rem),
        .wr_addr (wr_addr),
        .err     (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp_v);
        n_chk++;
        if (obs === exp_v) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, obs, exp_v);
    endtask

    task automatic ref_model(input logic [2:0] o, input logic [7:0] x,
                             input logic [7:0] y,
                             output logic [15:0] r, output logic [7:0] m,
                             output logic e, output logic [1:0] ad,
                             output int lat);
        r = 16'd0; m = 8'd0; e = 1'b0; ad = 2'd0; lat = 2;
        case (o)
            3'd1: begin r = 16'(x) + 16'(y); ad = 2'd0; end
            3'd2: begin r = 16'(x) * 16'(y); ad = 2'd1; lat = 9; end
            3'd3: begin r = 16'(x) - 16'(y); ad = 2'd2; end
            3'd4: begin
                ad = 2'd3;
                if (y == 8'd0) begin
                    r = 16'hFFFF; m = 8'hFF; e = 1'b1;
                end else begin
                    r = 16'(x / y); m = x % y; lat = 9;
                end
            end
            default: ;
        endcase
    endtask

    task automatic check_outs(input string tag);
        chk({tag, "_res"}, 32'(result), 32'(e_res));
        chk({tag, "_rem"}, 32'(rem), 32'(e_rem));
        chk({tag, "_addr"}, 32'(wr_addr), 32'(e_addr));
        chk({tag, "_err"}, 32'(err), 32'(e_err));
    endtask

    task automatic do_op(input logic [2:0] o, input logic [7:0] x,
                         input logic [7:0] y);
        int lat;
        int n;
        ref_model(o, x, y, e_res, e_rem, e_err, e_addr, lat);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk);
        #1;
        start = 1'b0;
        op = 3'($urandom); a = 8'($urandom); b = 8'($urandom);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (!done) chk("busy_calc", 32'(busy), 32'd1);
        end while (!done && n < 20);
        chk("latency", 32'(n), 32'(lat));
        chk("busy_done", 32'(busy), 32'd1);
        check_outs("op");
        @(negedge clk);
        chk("busy_after", 32'(busy), 32'd0);
        chk("done_after", 32'(done), 32'd0);
    endtask

    initial begin
        int ndone;
        int lat;
        logic [2:0] ro;
        logic [7:0] rx;
        logic [7:0] ry;

        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        check_outs("rst");
        rst_n = 1'b1;
        @(negedge clk);

        do_op(3'd1, 8'hFF, 8'h01);
        do_op(3'd3, 8'h03, 8'h05);
        do_op(3'd3, 8'h05, 8'h03);
        do_op(3'd2, 8'hFF, 8'hFF);
        do_op(3'd2, 8'h00, 8'h7F);
        do_op(3'd4, 8'hC8, 8'h07);
        do_op(3'd4, 8'h10, 8'h00);

        // Requests during a mul, including the DONE cycle, are dropped.
        ref_model(3'd2, 8'h37, 8'h5A, e_res, e_rem, e_err, e_addr, lat);
        @(negedge clk);
        start = 1'b1; op = 3'd2; a = 8'h37; b = 8'h5A;
        @(posedge clk);
        #1 start = 1'b0;
        ndone = 0;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                chk("mi_lat", 32'(c), 32'd9);
                check_outs("mi");
            end
            if (c == 3 || c == 9) begin
                start = 1'b1; op = 3'd1; a = 8'h01; b = 8'h01;
                @(posedge clk);
                #1 start = 1'b0;
            end
        end
        chk("mi_ndone", 32'(ndone), 32'd1);
        check_outs("mi_hold");

        // Invalid op in IDLE.
        @(negedge clk);
        start = 1'b1; op = 3'b111; a = 8'h12; b = 8'h34;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("inv_busy", 32'(busy), 32'd0);
            chk("inv_done", 32'(done), 32'd0);
        end
        check_outs("inv");

        // Asynchronous reset in the middle of a divide.
        @(negedge clk);
        start = 1'b1; op = 3'd4; a = 8'hC8; b = 8'h07;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        e_res = 16'd0; e_rem = 8'd0; e_addr = 2'd0; e_err = 1'b0;
        chk("ar_busy", 32'(busy), 32'd0);
        chk("ar_done", 32'(done), 32'd0);
        check_outs("ar");
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("ar_nodone", 32'(ndone), 32'd0);
        do_op(3'd1, 8'h21, 8'h42);

        for (int i = 0; i < 30; i++) begin
            ro = 3'($urandom_range(1, 4));
            rx = 8'($urandom);
            ry = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom);
            do_op(ro, rx, ry);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
